requant_relu6_pipe: RTL and testbench

Parametrised requantization and activation stage for MobileNetV2 conv/depthwise outputs. It takes LANES int32 accumulators per beat and applies a per-channel fixed-point multiplier with a rounding right shift. It then adds the output zero point and clamps according to the activation mode (none/ReLU/ReLU6), producing LANES uint8 values. It sits between the conv accumulator array and the activation write-back buffer. Flow is valid/ready throughout, with a per-channel parameter table loaded through a config port.

---
 rtl/npu_quant_pkg.sv | 25 ++
 rtl/requant_relu6_pipe_if.sv | 25 ++
 rtl/requant_lane.sv | 133 +++++++++++++
 rtl/requant_relu6_pipe.sv | 139 +++++++++++++
 tb/tb_requant_relu6_pipe.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/npu_quant_pkg.sv
// Shared types and constants for the requantization / activation stage.
//   act_mode_e   : activation clamp selection (encoding 3 behaves like RELU6)
//   ACC_W/ACT_W  : accumulator and activation widths
//   chan_param_t : one entry of the per-channel parameter table
package npu_quant_pkg;

  localparam int ACC_W      = 32;
  localparam int ACT_W      = 8;
  localparam int SHIFT_W    = 5;
  // Table entries are sized for the default multiplier width; the top's
  // MULT_W parameter is expected to match it.
  localparam int MULT_W_DEF = 16;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    RELU  = 2'd1,
    RELU6 = 2'd2
  } act_mode_e;

  typedef struct packed {
    logic [MULT_W_DEF-1:0] mult;
    logic [SHIFT_W-1:0]    shift;
  } chan_param_t;

endpackage

// File: rtl/requant_relu6_pipe_if.sv
// Streaming bus of the requantization stage: an accumulator beat stream in
// and an activation beat stream out, both valid/ready.
//   slave  : the requant block (consumes in_*, produces out_*)
//   master : the producer/consumer side (testbench or neighbouring blocks)
interface requant_relu6_pipe_if #(
  parameter int LANES = 4
);
  logic                                   in_valid;
  logic                                   in_ready;
  logic [npu_quant_pkg::ACC_W*LANES-1:0]  in_acc;
  logic                                   in_last;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [npu_quant_pkg::ACT_W*LANES-1:0]  out_act;

  modport slave (
    input  in_valid, in_acc, in_last, out_ready,
    output in_ready, out_valid, out_act
  );

  modport master (
    output in_valid, in_acc, in_last, out_ready,
    input  in_ready, out_valid, out_act
  );
endinterface

// File: rtl/requant_lane.sv
// One lane of the requant datapath: multiply, rounding shift, zero-point add
// and clamp, one register stage each. Stage enables come from the top.
//   clock/reset    : clock and synchronous active-high reset
//   i_en1..i_en3   : load enables of stage 1 (product), 2 (rounded), 3 (out)
//   i_acc          : signed accumulator
//   i_mult/i_shift : channel multiplier and right shift for this beat
//   i_mode/i_zp/i_relu6_q : activation mode, zero point, RELU6 upper bound
//   o_act/o_clip   : registered uint8 result and "value was clamped" flag
module requant_lane
  import npu_quant_pkg::*;
#(
  parameter int MULT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_en1,
  input  logic               i_en2,
  input  logic               i_en3,
  input  logic [ACC_W-1:0]   i_acc,
  input  logic [MULT_W-1:0]  i_mult,
  input  logic [SHIFT_W-1:0] i_shift,
  input  logic [1:0]         i_mode,
  input  logic [ACT_W-1:0]   i_zp,
  input  logic [ACT_W-1:0]   i_relu6_q,
  output logic [ACT_W-1:0]   o_act,
  output logic               o_clip
);

  localparam int PROD_W = ACC_W + MULT_W;
  // One guard bit so adding the rounding constant cannot overflow.
  localparam int R_W    = PROD_W + 1;

  logic signed [PROD_W-1:0]  w_acc_x, w_mult_x, w_prod;
  logic signed [R_W-1:0]     w_prod_x, w_half, w_sum, w_rnd;
  logic signed [R_W-1:0]     w_v, w_zp_x, w_lo_x, w_hi_x;
  logic [ACT_W-1:0]          w_lo, w_hi, w_lo_eff, w_act;
  logic                      w_clip;

  logic signed [PROD_W-1:0]  r_prod;
  logic [SHIFT_W-1:0]        r_shift;
  logic signed [R_W-1:0]     r_rnd;
  logic [ACT_W-1:0]          r_act;
  logic                      r_clip;

  // Signed accumulator times unsigned multiplier, both widened to the product.
  assign w_acc_x  = {{MULT_W{i_acc[ACC_W-1]}}, i_acc};
  assign w_mult_x = {{ACC_W{1'b0}}, i_mult};
  assign w_prod   = w_acc_x * w_mult_x;

  assign w_prod_x = {r_prod[PROD_W-1], r_prod};
  assign w_sum    = w_prod_x + w_half;
  assign w_rnd    = w_sum >>> r_shift;

  // Round-half-up constant; a zero shift passes the product through.
  always_comb begin
    w_half = '0;
    if (r_shift == 5'd0) begin
      w_half = '0;
    end else begin
      w_half = {{(R_W-1){1'b0}}, 1'b1} << (r_shift - 5'd1);
    end
  end

  assign w_zp_x = {{(R_W-ACT_W){1'b0}}, i_zp};
  assign w_v    = r_rnd + w_zp_x;

  // Clamp bounds from the activation mode.
  always_comb begin
    w_lo = 8'h00;
    w_hi = 8'hFF;
    case (i_mode)
      NONE:    begin w_lo = 8'h00; w_hi = 8'hFF;      end
      RELU:    begin w_lo = i_zp;  w_hi = 8'hFF;      end
      default: begin w_lo = i_zp;  w_hi = i_relu6_q;  end
    endcase
  end

  // A RELU6 bound below the zero point collapses the range onto the upper bound.
  always_comb begin
    w_lo_eff = w_lo;
    if (w_lo > w_hi) begin
      w_lo_eff = w_hi;
    end else begin
      w_lo_eff = w_lo;
    end
  end

  assign w_lo_x = {{(R_W-ACT_W){1'b0}}, w_lo_eff};
  assign w_hi_x = {{(R_W-ACT_W){1'b0}}, w_hi};

  // Saturate to [lo, hi]; a value sitting exactly on a bound is not a clip.
  always_comb begin
    w_act  = w_v[ACT_W-1:0];
    w_clip = 1'b0;
    if (w_v < w_lo_x) begin
      w_act  = w_lo_eff;
      w_clip = 1'b1;
    end else if (w_v > w_hi_x) begin
      w_act  = w_hi;
      w_clip = 1'b1;
    end else begin
      w_act  = w_v[ACT_W-1:0];
      w_clip = 1'b0;
    end
  end

  // Three pipeline stages, each loaded only when its beat advances.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prod  <= '0;
      r_shift <= '0;
      r_rnd   <= '0;
      r_act   <= '0;
      r_clip  <= 1'b0;
    end else begin
      if (i_en1) begin
        r_prod  <= w_prod;
        r_shift <= i_shift;
      end
      if (i_en2) begin
        r_rnd <= w_rnd;
      end
      if (i_en3) begin
        r_act  <= w_act;
        r_clip <= w_clip;
      end
    end
  end

  assign o_act  = r_act;
  assign o_clip = r_clip;

endmodule

// File: rtl/requant_relu6_pipe.sv
// Requantization + ReLU/ReLU6 stage between the conv accumulator array and
// the activation write-back buffer. Holds the per-channel parameter table,
// the channel counter, the pipeline handshake and the clip counter.
//   clock/reset     : clock and synchronous active-high reset
//   bus (slave)     : accumulator beats in, uint8 activation beats out
//   cfg_we/addr/mult/shift : parameter table write port
//   cfg_num_ch      : active channel count (1..NUM_CH)
//   mode/out_zp/relu6_q : activation mode, output zero point, RELU6 bound
//   clip_clear/clip_cnt : clear and saturating count of clamped lanes
module requant_relu6_pipe
  import npu_quant_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int NUM_CH = 64,
  parameter int MULT_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  requant_relu6_pipe_if.slave         bus,
  input  logic                        cfg_we,
  input  logic [$clog2(NUM_CH)-1:0]   cfg_addr,
  input  logic [MULT_W-1:0]           cfg_mult,
  input  logic [SHIFT_W-1:0]          cfg_shift,
  input  logic [$clog2(NUM_CH):0]     cfg_num_ch,
  input  logic [1:0]                  mode,
  input  logic [ACT_W-1:0]            out_zp,
  input  logic [ACT_W-1:0]            relu6_q,
  input  logic                        clip_clear,
  output logic [CNT_W-1:0]            clip_cnt
);

  localparam int AW = $clog2(NUM_CH);

  chan_param_t              r_tbl [NUM_CH];
  logic [AW-1:0]            r_ch_idx;
  logic                     r_v1, r_v2, r_out_valid;
  logic [CNT_W-1:0]         r_clip_cnt;

  logic                     w_en, w_accept, w_en1, w_en2, w_en3;
  chan_param_t              w_prm;
  logic [AW:0]              w_last_ch;
  logic [LANES*ACT_W-1:0]   w_act;
  logic [LANES-1:0]         w_clip;
  logic [CNT_W:0]           w_clip_n, w_cnt_sum;

  // The whole pipeline moves as one: it stalls only when the output is held.
  assign w_en     = !r_out_valid || bus.out_ready;
  assign w_accept = bus.in_valid && w_en;
  assign w_en1    = w_accept;
  assign w_en2    = w_en && r_v1;
  assign w_en3    = w_en && r_v2;

  // Read before this cycle's write lands, so a same-address write is seen next beat.
  assign w_prm     = r_tbl[r_ch_idx];
  assign w_last_ch = cfg_num_ch - {{AW{1'b0}}, 1'b1};

  // Per-channel parameter table.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_tbl[i] <= '0;
      end
    end else if (cfg_we) begin
      r_tbl[cfg_addr] <= '{mult: cfg_mult, shift: cfg_shift};
    end
  end

  // Channel counter: wraps at the active channel count or on the tile's last beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ch_idx <= '0;
    end else if (w_accept) begin
      if (bus.in_last || ({1'b0, r_ch_idx} == w_last_ch)) begin
        r_ch_idx <= '0;
      end else begin
        r_ch_idx <= r_ch_idx + {{(AW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Stage valid chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_en) begin
      r_v1        <= bus.in_valid;
      r_v2        <= r_v1;
      r_out_valid <= r_v2;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    requant_lane #(.MULT_W(MULT_W)) u_lane (
      .clock     (clock),
      .reset     (reset),
      .i_en1     (w_en1),
      .i_en2     (w_en2),
      .i_en3     (w_en3),
      .i_acc     (bus.in_acc[g*ACC_W +: ACC_W]),
      .i_mult    (w_prm.mult),
      .i_shift   (w_prm.shift),
      .i_mode    (mode),
      .i_zp      (out_zp),
      .i_relu6_q (relu6_q),
      .o_act     (w_act[g*ACT_W +: ACT_W]),
      .o_clip    (w_clip[g])
    );
  end

  // Number of clamped lanes in the beat at the output register.
  always_comb begin
    w_clip_n = '0;
    for (int i = 0; i < LANES; i++) begin
      w_clip_n = w_clip_n + {{CNT_W{1'b0}}, w_clip[i]};
    end
  end

  assign w_cnt_sum = {1'b0, r_clip_cnt} + w_clip_n;

  // Saturating clip counter, counted when a beat leaves; clear wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_clip_cnt <= '0;
    end else if (clip_clear) begin
      r_clip_cnt <= '0;
    end else if (r_out_valid && bus.out_ready) begin
      r_clip_cnt <= w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
    end
  end

  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_out_valid;
  assign bus.out_act   = w_act;
  assign clip_cnt      = r_clip_cnt;

endmodule

// File: tb/tb_requant_relu6_pipe.sv
// Directed self-checking bench for requant_relu6_pipe.
module tb_requant_relu6_pipe;

  logic        clock;
  logic        reset;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [15:0] cfg_mult;
  logic [4:0]  cfg_shift;
  logic [6:0]  cfg_num_ch;
  logic [1:0]  mode;
  logic [7:0]  out_zp;
  logic [7:0]  relu6_q;
  logic        clip_clear;
  logic [15:0] clip_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] s_acc  [32];
  logic         s_last [32];
  logic [31:0]  s_exp  [32];
  int           n_beats = 0;

  requant_relu6_pipe_if #(.LANES(4)) ifc ();

  requant_relu6_pipe #(
    .LANES(4), .NUM_CH(64), .MULT_W(16), .CNT_W(16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (ifc),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_mult   (cfg_mult),
    .cfg_shift  (cfg_shift),
    .cfg_num_ch (cfg_num_ch),
    .mode       (mode),
    .out_zp     (out_zp),
    .relu6_q    (relu6_q),
    .clip_clear (clip_clear),
    .clip_cnt   (clip_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [127:0] acc4(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  task automatic add_beat(input logic [127:0] acc, input logic last, input logic [31:0] exp_v);
    s_acc[n_beats]  = acc;
    s_last[n_beats] = last;
    s_exp[n_beats]  = exp_v;
    n_beats++;
  endtask

  task automatic cfgw(input logic [5:0] a, input logic [15:0] m, input logic [4:0] s);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_mult  = m;
    cfg_shift = s;
    @(posedge clock); #1;
    cfg_we    = 1'b0;
  endtask

  // Push the queued beats, collecting outputs under an out_ready pattern.
  task automatic run_stream(input string tag, input logic [3:0] pat, input bit chk_rdy,
                            output int lat);
    int si, ei, cyc, c0;
    si = 0; ei = 0; cyc = 0; c0 = 0; lat = -1;
    while ((ei < n_beats) && (cyc < 200)) begin
      ifc.out_ready = pat[cyc % 4];
      ifc.in_valid  = (si < n_beats);
      ifc.in_acc    = (si < n_beats) ? s_acc[si] : 128'd0;
      ifc.in_last   = (si < n_beats) ? s_last[si] : 1'b0;
      #1;
      if (chk_rdy) chk({tag, " in_ready"}, 64'(ifc.in_ready), 64'(!ifc.out_valid || ifc.out_ready));
      if (ifc.out_valid && ifc.out_ready) begin
        chk($sformatf("%s beat%0d", tag, ei), 64'(ifc.out_act), 64'(s_exp[ei]));
        if (ei == 0) lat = cyc - c0;
        ei++;
      end
      if (ifc.in_valid && ifc.in_ready) begin
        if (si == 0) c0 = cyc;
        si++;
      end
      @(posedge clock); #1;
      cyc++;
    end
    ifc.in_valid  = 1'b0;
    ifc.in_last   = 1'b0;
    ifc.out_ready = 1'b1;
    chk({tag, " count"}, 64'(ei), 64'(n_beats));
    #1;
    chk({tag, " drain"}, 64'(ifc.out_valid), 64'd0);
    n_beats = 0;
  endtask

  initial begin
    int lat;
    int seen;
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = 6'd0; cfg_mult = 16'd0; cfg_shift = 5'd0;
    cfg_num_ch = 7'd1; mode = 2'd0; out_zp = 8'd0; relu6_q = 8'd255; clip_clear = 1'b0;
    ifc.in_valid = 1'b0; ifc.in_acc = 128'd0; ifc.in_last = 1'b0; ifc.out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("rst out_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst in_ready", 64'(ifc.in_ready), 64'd1);
    chk("rst out_act", 64'(ifc.out_act), 64'd0);
    chk("rst clip_cnt", 64'(clip_cnt), 64'd0);
    @(posedge clock); #1;

    // Pass-through, RELU6 with full-range bound.
    mode = 2'd2; out_zp = 8'd0; relu6_q = 8'd255;
    cfgw(6'd0, 16'd1, 5'd0);
    add_beat(acc4(-5, 0, 100, 300), 1'b0, 32'hFF640000);
    run_stream("pass", 4'hF, 1'b0, lat);
    chk("pass latency", 64'(lat), 64'd3);
    chk("pass clip", 64'(clip_cnt), 64'd2);

    // Rounding shift with zero point 128, no activation.
    mode = 2'd0; out_zp = 8'd128;
    cfgw(6'd0, 16'd3, 5'd2);
    add_beat(acc4(10, -10, 2, -2), 1'b0, 32'h7F827988);
    run_stream("round", 4'hF, 1'b0, lat);
    chk("round clip", 64'(clip_cnt), 64'd2);

    // RELU floor at the zero point, then RELU6 ceiling.
    mode = 2'd1; out_zp = 8'd20;
    cfgw(6'd0, 16'd1, 5'd0);
    add_beat(acc4(-50, -21, 5, 400), 1'b0, 32'hFF191414);
    run_stream("relu", 4'hF, 1'b0, lat);
    chk("relu clip", 64'(clip_cnt), 64'd5);
    mode = 2'd2; relu6_q = 8'd60;
    add_beat(acc4(-50, -21, 5, 400), 1'b0, 32'h3C191414);
    run_stream("relu6", 4'hF, 1'b0, lat);
    chk("relu6 clip", 64'(clip_cnt), 64'd8);

    // Upper bound below the zero point: every lane reads relu6_q.
    relu6_q = 8'd10;
    add_beat(acc4(-50, 15, 100, 0), 1'b0, 32'h0A0A0A0A);
    run_stream("hiwins", 4'hF, 1'b0, lat);
    chk("hiwins clip", 64'(clip_cnt), 64'd12);

    // Backpressure with out_ready 1,0,0,1.
    mode = 2'd0; out_zp = 8'd0;
    for (int k = 0; k < 8; k++) begin
      add_beat(acc4(10*k+1, 10*k+2, 10*k+3, 10*k+4), 1'b0,
               {8'(10*k+4), 8'(10*k+3), 8'(10*k+2), 8'(10*k+1)});
    end
    run_stream("bp", 4'b1001, 1'b1, lat);
    chk("bp clip", 64'(clip_cnt), 64'd12);

    // Channel wrap over three channels, multipliers 1/2/3.
    cfg_num_ch = 7'd3;
    cfgw(6'd0, 16'd1, 5'd0);
    cfgw(6'd1, 16'd2, 5'd0);
    cfgw(6'd2, 16'd3, 5'd0);
    add_beat(acc4(10, 10, 10, 10), 1'b0, 32'h0A0A0A0A);
    add_beat(acc4(10, 10, 10, 10), 1'b0, 32'h14141414);
    add_beat(acc4(10, 10, 10, 10), 1'b0, 32'h1E1E1E1E);
    add_beat(acc4(10, 10, 10, 10), 1'b0, 32'h0A0A0A0A);
    add_beat(acc4(10, 10, 10, 10), 1'b0, 32'h14141414);
    add_beat(acc4(10, 10, 10, 10), 1'b0, 32'h1E1E1E1E);
    add_beat(acc4(10, 10, 10, 10), 1'b0, 32'h0A0A0A0A);
    run_stream("wrap", 4'hF, 1'b0, lat);
    // Counter now at channel 1; in_last forces the following beat to channel 0.
    add_beat(acc4(10, 10, 10, 10), 1'b1, 32'h14141414);
    add_beat(acc4(10, 10, 10, 10), 1'b0, 32'h0A0A0A0A);
    add_beat(acc4(10, 10, 10, 10), 1'b1, 32'h14141414);
    add_beat(acc4(10, 10, 10, 10), 1'b0, 32'h0A0A0A0A);
    run_stream("last", 4'hF, 1'b0, lat);

    // Saturate the clip counter with all-lanes-clamped beats.
    ifc.in_acc = acc4(-1, -1, -1, -1); ifc.in_last = 1'b0; ifc.out_ready = 1'b1;
    ifc.in_valid = 1'b1;
    repeat (16500) @(posedge clock);
    #1;
    ifc.in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("sat clip", 64'(clip_cnt), 64'hFFFF);

    // Clear coinciding with a clamped beat leaving the pipe.
    ifc.in_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("sat hold", 64'(clip_cnt), 64'hFFFF);
    clip_clear = 1'b1; ifc.in_valid = 1'b0;
    @(posedge clock); #1;
    clip_clear = 1'b0;
    chk("clear wins", 64'(clip_cnt), 64'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("after clear", 64'(clip_cnt), 64'd8);

    // Reset in the middle of a stream drops the in-flight beats.
    ifc.in_valid = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("midrst out_valid", 64'(ifc.out_valid), 64'd0);
    chk("midrst clip", 64'(clip_cnt), 64'd0);
    chk("midrst out_act", 64'(ifc.out_act), 64'd0);
    reset = 1'b0; ifc.in_valid = 1'b0;
    seen = 0;
    repeat (5) begin
      @(posedge clock); #1;
      if (ifc.out_valid) seen++;
    end
    chk("midrst stale", 64'(seen), 64'd0);

    // Table entries come back as mult=0 after reset, so the output is the zero point.
    mode = 2'd0; out_zp = 8'd7; cfg_num_ch = 7'd1;
    add_beat(acc4(100, -100, 5, 9), 1'b0, 32'h07070707);
    run_stream("tblrst", 4'hF, 1'b0, lat);
    chk("tblrst clip", 64'(clip_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
